sram_1p_masked_pipe: RTL and testbench

- Parametrised single-port synchronous SRAM model with per-lane write mask. It is the generalised successor of the fixed-geometry array models.
- Adds configurable depth, width and mask granularity, a configurable read-latency pipeline with a valid strobe, and a post-reset clear state machine with a ready indication.
- Used as the behavioural storage macro under cache data/tag arrays in simulation and formal flows.

---
 rtl/sram_1p_masked_pipe.sv | 114 +++++++++++
 tb/tb_sram_1p_masked_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sram_1p_masked_pipe.sv
// Single-port SRAM model with per-lane write mask, post-reset clear sequence
// and a fixed-latency read pipeline with a valid strobe.

module sram_1p_masked_pipe_lane #(
   parameter int LANE  = 98,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [LANE-1:0] wdata,
   output logic [LANE-1:0] rdata
);
   logic [LANE-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;

   assign rdata = mem[addr];
endmodule

module sram_1p_masked_pipe #(
   parameter int WIDTH      = 392,
   parameter int DEPTH      = 4,
   parameter int MASK_BITS  = 4,
   parameter int RD_LATENCY = 1,
   parameter bit INIT_VALUE = 1'b0,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 RW0_clk,
   input  logic                 RW0_rst_n,
   input  logic [AW-1:0]        RW0_addr,
   input  logic                 RW0_en,
   input  logic                 RW0_wmode,
   input  logic [MASK_BITS-1:0] RW0_wmask,
   input  logic [WIDTH-1:0]     RW0_wdata,
   output logic [WIDTH-1:0]     RW0_rdata,
   output logic                 RW0_rvalid,
   output logic                 RW0_ready
);
   localparam int LANE   = WIDTH / MASK_BITS;
   localparam int STAGES = RD_LATENCY - 1;

   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

   state_t                             state, state_nxt;
   logic [AW-1:0]                      clr_cnt;
   logic                               clr_we, clr_last;
   logic                               accept, acc_rd, acc_wr, in_range;
   logic [AW-1:0]                      mem_addr;
   logic [MASK_BITS-1:0][LANE-1:0]     lane_rd;
   logic [WIDTH-1:0]                   rd_word;
   logic [STAGES:0]                    vld_pipe;
   logic [STAGES:0][WIDTH-1:0]         dat_pipe;

   assign clr_last = (clr_cnt == AW'(DEPTH - 1));

   always_ff @(posedge RW0_clk or negedge RW0_rst_n)
      if (!RW0_rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (clr_we) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && clr_last) state_nxt = IDLE;
   end

   always_comb begin
      clr_we    = (state == CLEAR);
      RW0_ready = (state == IDLE);
   end

   assign accept   = RW0_en & RW0_ready;
   assign acc_wr   = accept & RW0_wmode;
   assign acc_rd   = accept & ~RW0_wmode;
   // Only non-power-of-two depths can present an address past the last entry.
   assign in_range = (32'(RW0_addr) < DEPTH);
   assign mem_addr = clr_we ? clr_cnt : RW0_addr;

   for (genvar i = 0; i < MASK_BITS; i++) begin : g_lane
      sram_1p_masked_pipe_lane #(.LANE(LANE), .DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk   (RW0_clk),
         .we    (clr_we | (acc_wr & in_range & RW0_wmask[i])),
         .addr  (mem_addr),
         .wdata (clr_we ? {LANE{INIT_VALUE}} : RW0_wdata[i*LANE +: LANE]),
         .rdata (lane_rd[i])
      );
   end

   assign rd_word = in_range ? lane_rd : '0;

   // Each stage loads only behind a valid bit, so the last stage naturally
   // holds the most recent return between pulses.
   always_ff @(posedge RW0_clk or negedge RW0_rst_n)
      if (!RW0_rst_n) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[0] <= acc_rd;
         if (acc_rd) dat_pipe[0] <= rd_word;
         for (int s = 1; s <= STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
         end
      end

   assign RW0_rvalid = vld_pipe[STAGES];
   assign RW0_rdata  = dat_pipe[STAGES];
endmodule

// File: tb/tb_sram_1p_masked_pipe.sv
// Directed bench: a 392-bit/depth-4/latency-3 instance and a 16-bit/depth-5/latency-2 instance.

module tb_sram_1p_masked_pipe;
   logic         clk;
   logic         a_rst_n, a_en, a_wmode, a_rvalid, a_ready;
   logic [1:0]   a_addr;
   logic [3:0]   a_wmask;
   logic [391:0] a_wdata, a_rdata;
   logic         b_rst_n, b_en, b_wmode, b_rvalid, b_ready;
   logic [2:0]   b_addr;
   logic [3:0]   b_wmask;
   logic [15:0]  b_wdata, b_rdata;
   int           n_chk, n_pass;
   logic [391:0] pat;

   sram_1p_masked_pipe #(.WIDTH(392), .DEPTH(4), .MASK_BITS(4), .RD_LATENCY(3)) u_a (
      .RW0_clk(clk), .RW0_rst_n(a_rst_n), .RW0_addr(a_addr), .RW0_en(a_en),
      .RW0_wmode(a_wmode), .RW0_wmask(a_wmask), .RW0_wdata(a_wdata),
      .RW0_rdata(a_rdata), .RW0_rvalid(a_rvalid), .RW0_ready(a_ready));

   sram_1p_masked_pipe #(.WIDTH(16), .DEPTH(5), .MASK_BITS(4), .RD_LATENCY(2)) u_b (
      .RW0_clk(clk), .RW0_rst_n(b_rst_n), .RW0_addr(b_addr), .RW0_en(b_en),
      .RW0_wmode(b_wmode), .RW0_wmask(b_wmask), .RW0_wdata(b_wdata),
      .RW0_rdata(b_rdata), .RW0_rvalid(b_rvalid), .RW0_ready(b_ready));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [391:0] got, input logic [391:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h exp %h", tag, got, exp);
   endtask

   task automatic a_wr(input logic [1:0] addr, input logic [391:0] data, input logic [3:0] mask);
      @(negedge clk);
      a_en = 1'b1; a_wmode = 1'b1; a_addr = addr; a_wdata = data; a_wmask = mask;
      @(negedge clk);
      a_en = 1'b0;
   endtask

   task automatic a_rd_chk(input logic [1:0] addr, input logic [391:0] exp, input string tag);
      @(negedge clk);
      a_en = 1'b1; a_wmode = 1'b0; a_addr = addr;
      @(negedge clk);
      a_en = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, "_vld"}, 392'(a_rvalid), 392'(1'b1));
      chk(tag, a_rdata, exp);
   endtask

   task automatic b_wr(input logic [2:0] addr, input logic [15:0] data, input logic [3:0] mask);
      @(negedge clk);
      b_en = 1'b1; b_wmode = 1'b1; b_addr = addr; b_wdata = data; b_wmask = mask;
      @(negedge clk);
      b_en = 1'b0;
   endtask

   task automatic b_rd_chk(input logic [2:0] addr, input logic [15:0] exp, input string tag);
      @(negedge clk);
      b_en = 1'b1; b_wmode = 1'b0; b_addr = addr;
      @(negedge clk);
      b_en = 1'b0;
      @(negedge clk);
      chk({tag, "_vld"}, 392'(b_rvalid), 392'(1'b1));
      chk(tag, 392'(b_rdata), 392'(exp));
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      a_rst_n = 1'b0; a_en = 1'b0; a_wmode = 1'b0; a_addr = '0; a_wmask = '0; a_wdata = '0;
      b_rst_n = 1'b0; b_en = 1'b0; b_wmode = 1'b0; b_addr = '0; b_wmask = '0; b_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 392'(a_ready), 392'(1'b0));
      chk("rst_rvalid", 392'(a_rvalid), 392'(1'b0));
      chk("rst_rdata", a_rdata, '0);

      // B keeps requesting a write to entry 0 all through CLEAR; none may land.
      @(negedge clk);
      b_en = 1'b1; b_wmode = 1'b1; b_addr = 3'd0; b_wdata = 16'hFFFF; b_wmask = 4'hF;
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("a_clr_rdy%0d", k), 392'(a_ready), 392'(k >= 4));
         chk($sformatf("b_clr_rdy%0d", k), 392'(b_ready), 392'(k >= 5));
      end
      b_en = 1'b0;
      chk("b_clr_no_rvalid", 392'(b_rvalid), 392'(1'b0));

      for (int i = 0; i < 4; i++) a_rd_chk(2'(i), '0, $sformatf("a_clr_rd%0d", i));
      b_rd_chk(3'd0, 16'h0000, "b_ign_wr");

      // Masked write: lanes 1 and 3 keep the ones.
      a_wr(2'd2, {392{1'b1}}, 4'b1111);
      a_wr(2'd2, '0, 4'b0101);
      pat = {{98{1'b1}}, {98{1'b0}}, {98{1'b1}}, {98{1'b0}}};
      a_rd_chk(2'd2, pat, "a_mask_rd");
      a_wr(2'd2, '0, 4'b0000);
      chk("a_wr_no_rvalid", 392'(a_rvalid), 392'(1'b0));
      chk("a_wr_rdata_hold", a_rdata, pat);
      a_rd_chk(2'd2, pat, "a_mask0_rd");

      // Back-to-back reads with latency 3.
      for (int i = 0; i < 4; i++) a_wr(2'(i), 392'(10 + i), 4'hF);
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         if (k >= 1 && k <= 2) chk($sformatf("a_lat_idle%0d", k), 392'(a_rvalid), 392'(1'b0));
         if (k >= 3 && k <= 6) begin
            chk($sformatf("a_lat_vld%0d", k), 392'(a_rvalid), 392'(1'b1));
            chk($sformatf("a_lat_dat%0d", k), a_rdata, 392'(10 + k - 3));
         end
         if (k >= 7) begin
            chk($sformatf("a_lat_end_vld%0d", k), 392'(a_rvalid), 392'(1'b0));
            chk($sformatf("a_lat_end_dat%0d", k), a_rdata, 392'(13));
         end
         if (k <= 3) begin
            a_en = 1'b1; a_wmode = 1'b0; a_addr = 2'(k);
         end else a_en = 1'b0;
      end

      // Out-of-range on the depth-5 instance.
      for (int i = 0; i < 5; i++) b_wr(3'(i), 16'(32'h1110 + i), 4'hF);
      b_rd_chk(3'd4, 16'h1114, "b_pre_oor");
      b_wr(3'd6, 16'hFFFF, 4'hF);
      b_rd_chk(3'd7, 16'h0000, "b_oor_rd");
      for (int i = 0; i < 5; i++) b_rd_chk(3'(i), 16'(32'h1110 + i), $sformatf("b_oor_keep%0d", i));

      // Snapshot: the in-flight read ignores the following write.
      b_wr(3'd1, 16'h0005, 4'hF);
      @(negedge clk);
      b_en = 1'b1; b_wmode = 1'b0; b_addr = 3'd1;
      @(negedge clk);
      chk("b_snap_idle", 392'(b_rvalid), 392'(1'b0));
      b_wmode = 1'b1; b_wdata = 16'h0009; b_wmask = 4'hF;
      @(negedge clk);
      chk("b_snap_vld", 392'(b_rvalid), 392'(1'b1));
      chk("b_snap_dat", 392'(b_rdata), 392'(16'h0005));
      b_wmode = 1'b0;
      @(negedge clk);
      chk("b_snap_gap", 392'(b_rvalid), 392'(1'b0));
      chk("b_snap_hold", 392'(b_rdata), 392'(16'h0005));
      b_en = 1'b0;
      @(negedge clk);
      chk("b_snap2_vld", 392'(b_rvalid), 392'(1'b1));
      chk("b_snap2_dat", 392'(b_rdata), 392'(16'h0009));

      // Reset while a read is in flight.
      @(negedge clk);
      b_en = 1'b1; b_wmode = 1'b0; b_addr = 3'd4;
      @(negedge clk);
      b_en = 1'b0; b_rst_n = 1'b0;
      #1;
      chk("b_mrst_rdata", 392'(b_rdata), '0);
      chk("b_mrst_rvalid", 392'(b_rvalid), 392'(1'b0));
      chk("b_mrst_ready", 392'(b_ready), 392'(1'b0));
      @(negedge clk);
      chk("b_mrst_drop", 392'(b_rvalid), 392'(1'b0));
      b_rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("b_mrst_vld%0d", k), 392'(b_rvalid), 392'(1'b0));
         chk($sformatf("b_mrst_rdy%0d", k), 392'(b_ready), 392'(k >= 5));
      end
      b_rd_chk(3'd1, 16'h0000, "b_mrst_clr1");
      b_rd_chk(3'd4, 16'h0000, "b_mrst_clr4");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
